alu_arbiter: RTL

Shares one 4-bit, 8-operation ALU between two requesters. Each requester presents an opcode and operands on a valid/ready channel. Requests are granted round-robin and executed one at a time. Results return on a single response channel tagged with the requester ID. The block sits between the two command sources and the shared arithmetic datapath, and adds a divide/modulus-by-zero error flag and a completed-operation counter.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit, 8-op ALU between two valid/ready requesters.
// One command in flight: IDLE accepts, EXEC evaluates and registers, RESP holds until accepted.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_sel,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_sel,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [3:0]       resp_out,
    output logic             resp_carry,
    output logic             resp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [2:0]         sel_q, sel_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic               id_q, id_d;
    logic [3:0]         out_q, out_d;
    logic               carry_q, carry_d, err_q, err_d, rid_q, rid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0] alu_out;
    logic       alu_carry, alu_err;
    logic [4:0] sum5, diff5;

    // Zero-extended 5-bit forms: bit 4 is the carry (add) or the borrow, i.e. a<b (sub).
    assign sum5  = {1'b0, a_q} + {1'b0, b_q};
    assign diff5 = {1'b0, a_q} - {1'b0, b_q};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_out   = 4'h0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (sel_q)
            3'b000: {alu_carry, alu_out} = sum5;
            3'b001: {alu_carry, alu_out} = diff5;
            3'b010: if (b_q == 4'h0) begin alu_out = 4'hF; alu_err = 1'b1; end
                    else alu_out = a_q / b_q;
            3'b011: if (b_q == 4'h0) begin alu_out = 4'hF; alu_err = 1'b1; end
                    else alu_out = a_q % b_q;
            3'b100: alu_out = a_q | b_q;
            3'b101: alu_out = a_q & b_q;
            3'b110: alu_out = a_q ^ b_q;
            default: alu_out = ~a_q;
        endcase
    end

    // The requester not served last wins a tie; ready never looks at resp_ready.
    assign req0_ready = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
    assign req1_ready = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        out_d        = out_q;
        carry_d      = carry_q;
        err_d        = err_q;
        rid_d        = rid_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    {sel_d, a_d, b_d} = {req0_sel, req0_a, req0_b};
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (req1_ready) begin
                    {sel_d, a_d, b_d} = {req1_sel, req1_a, req1_b};
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                out_d   = alu_out;
                carry_d = alu_carry;
                err_d   = alu_err;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 3'b000;
            a_q          <= 4'h0;
            b_q          <= 4'h0;
            id_q         <= 1'b0;
            out_q        <= 4'h0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
            rid_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            out_q        <= out_d;
            carry_q      <= carry_d;
            err_q        <= err_d;
            rid_q        <= rid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = rid_q;
    assign resp_out   = out_q;
    assign resp_carry = carry_q;
    assign resp_err   = err_q;
    assign op_count   = cnt_q;

endmodule
